// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial transmit path.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_DATA_W = 8;

    function automatic int unsigned bit_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Slot counter for piso_tx: counts 0..MAX, flags the final slot.
module bit_counter
    import shift_pkg::*;
#(
    parameter int unsigned MAX = 7,
    localparam int unsigned CW = bit_cnt_w(MAX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CW'(MAX));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding register for gapless streaming.
// Optional even parity slot after the data bits when PISO_PARITY_EN is defined.
module piso_tx
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              dout_en,
    output logic              word_done
);

`ifdef PISO_PARITY_EN
    localparam int unsigned NBITS = DATA_W + 1;
`else
    localparam int unsigned NBITS = DATA_W;
`endif
    localparam int unsigned   CW         = bit_cnt_w(NBITS - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(NBITS - 2);

    // The frame is laid out so the bit on air always sits at the shifter's output end.
    function automatic logic [NBITS-1:0] frame(input logic [DATA_W-1:0] w);
`ifdef PISO_PARITY_EN
        if (MSB_FIRST) begin
            return {w, ^w};
        end else begin
            return {^w, w};
        end
`else
        return w;
`endif
    endfunction

    state_e            state_q;
    logic [NBITS-1:0]  shreg_q;
    logic [NBITS-1:0]  shreg_shifted;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic              hold_full_d;
    logic              in_ready_q;
    logic              word_done_q;
    logic              accept;
    logic [CW-1:0]     cnt;
    logic              cnt_last;
    logic              cnt_clr;
    logic              cnt_inc;

    assign accept  = in_valid && in_ready_q;
    assign cnt_clr = (state_q == SHIFT) && cnt_last;
    assign cnt_inc = (state_q == SHIFT) && !cnt_last;

    assign shreg_shifted = MSB_FIRST ? {shreg_q[NBITS-2:0], 1'b0} : {1'b0, shreg_q[NBITS-1:1]};

    bit_counter #(
        .MAX (NBITS - 1)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // On the last slot the hold register always drains (or was already empty).
    always_comb begin
        hold_full_d = hold_full_q;
        if (state_q == SHIFT) begin
            if (cnt_last) begin
                hold_full_d = 1'b0;
            end else if (accept) begin
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            in_ready_q  <= !hold_full_d;
            word_done_q <= (state_q == SHIFT) && !cnt_last && (cnt == CNT_PENULT);
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q <= frame(data_in);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!cnt_last) begin
                        shreg_q <= shreg_shifted;
                        if (accept) begin
                            hold_q <= data_in;
                        end
                    end else if (hold_full_q) begin
                        shreg_q <= frame(hold_q);
                    end else if (accept) begin
                        shreg_q <= frame(data_in);
                    end else begin
                        shreg_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign dout      = MSB_FIRST ? shreg_q[NBITS-1] : shreg_q[0];
    assign dout_en   = (state_q == SHIFT);
    assign word_done = word_done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: directed cases plus randomized traffic against a bit-queue reference model.
module tb_piso_tx;

    localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
    localparam int unsigned NB = W + 1;
`else
    localparam int unsigned NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         in_valid = 1'b0;
    logic         rdy_m, dout_m, en_m, done_m;
    logic         rdy_l, dout_l, en_l, done_l;
    logic [7:0]   sr;

    int errors = 0;
    int checks = 0;

    // Reference: each DUT's future output is a queue of {last, bit} per slot.
    logic [1:0] qm[$];
    logic [1:0] ql[$];
    bit         m_en = 1'b0;

    always #15 clk = ~clk;

    piso_tx #(.DATA_W(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy_m), .dout(dout_m), .dout_en(en_m), .word_done(done_m)
    );

    piso_tx #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy_l), .dout(dout_l), .dout_en(en_l), .word_done(done_l)
    );

    // Downstream 8-bit serial-in shift register fed by dout.
    always @(posedge clk or negedge reset) begin
        if (!reset) sr <= '0;
        else        sr <= {sr[6:0], dout_m};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ready_m();
        return m_en && (qm.size() <= NB);
    endfunction

    function automatic void push_frame(input logic [W-1:0] w);
        logic bm, bl, lst;
        for (int i = 0; i < int'(NB); i++) begin
            if (i < int'(W)) begin
                bm = w[W-1-i];
                bl = w[i];
            end else begin
                bm = ^w;
                bl = ^w;
            end
            lst = (i == int'(NB) - 1);
            qm.push_back({lst, bm});
            ql.push_back({lst, bl});
        end
    endfunction

    task automatic check_outputs();
        logic em, el;
        em = qm.size() > 0;
        el = ql.size() > 0;
        check("dout_en", en_m, em);
        check("dout", dout_m, em ? qm[0][0] : 1'b0);
        check("word_done", done_m, em ? qm[0][1] : 1'b0);
        check("in_ready", rdy_m, ready_m());
        check("dout_en_lsb", en_l, el);
        check("dout_lsb", dout_l, el ? ql[0][0] : 1'b0);
        check("word_done_lsb", done_l, el ? ql[0][1] : 1'b0);
        check("in_ready_lsb", rdy_l, ready_m());
    endtask

    // Drive inputs, advance one clock, update the model, compare at the falling edge.
    task automatic tick(input logic v, input logic [W-1:0] d);
        bit acc;
        in_valid = v;
        data_in  = d;
        acc = v && ready_m();
        @(posedge clk);
        if (qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (acc) push_frame(d);
        m_en = 1'b1;
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset asserted mid-cycle, held one full period with in_valid high.
    task automatic do_reset();
        #5;
        reset    = 1'b0;
        in_valid = 1'b1;
        data_in  = W'($urandom);
        qm.delete();
        ql.delete();
        m_en = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        #1;
        check_outputs();
    endtask

    initial begin
        logic [7:0] got;
        int         cnt;

        // 1: reset with in_valid high
        #1;
        reset    = 1'b0;
        in_valid = 1'b1;
        data_in  = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        check("rst_in_ready", rdy_m, 1'b0);
        reset = 1'b1;
        #1;
        check_outputs();
        @(negedge clk);
        tick(1'b0, '0);
        check("ready_after_rst", rdy_m, 1'b1);

        // 2: single word A5
        got = '0;
        tick(1'b1, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(1'b0, '0);
            got[7-i] = dout_m;
            if (i == 7) check("a5_done_slot8", done_m, (NB == W) ? 1'b1 : 1'b0);
        end
        check("a5_serial", got, 8'hA5);
        tick(1'b0, '0);
        check("a5_shiftreg", sr, 8'hA5);
        repeat (NB + 2) tick(1'b0, '0);

        // 3: back-to-back FF then 00
        cnt = 0;
        tick(1'b1, 8'hFF);
        if (en_m) cnt++;
        tick(1'b1, 8'h00);
        if (en_m) cnt++;
        check("b2b_hold_ready", rdy_m, 1'b0);
        for (int i = 0; i < int'(2 * NB) + 2; i++) begin
            tick(1'b0, '0);
            if (en_m) cnt++;
        end
        check("b2b_en_cycles", cnt, 2 * NB);

        // 4: reset mid-word, then a clean word
        tick(1'b1, 8'hC3);
        repeat (3) tick(1'b0, '0);
        do_reset();
        tick(1'b0, '0);
        got = '0;
        tick(1'b1, 8'h81);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(1'b0, '0);
            got[7-i] = dout_m;
        end
        check("after_rst_81", got, 8'h81);
        repeat (NB + 2) tick(1'b0, '0);

`ifdef PISO_PARITY_EN
        // 5: parity slot
        tick(1'b1, 8'h07);
        for (int i = 1; i < int'(NB); i++) tick(1'b0, '0);
        check("parity_07", dout_m, 1'b1);
        check("parity_07_done", done_m, 1'b1);
        tick(1'b1, 8'h03);
        for (int i = 1; i < int'(NB); i++) tick(1'b0, '0);
        check("parity_03", dout_m, 1'b0);
        check("parity_03_done", done_m, 1'b1);
        repeat (NB + 2) tick(1'b0, '0);
`endif

        // 6: LSB-first instance, word 01
        got = '0;
        tick(1'b1, 8'h01);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(1'b0, '0);
            got[i] = dout_l;
        end
        check("lsb_first_01", got, 8'h01);
        repeat (NB + 2) tick(1'b0, '0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                tick(($urandom_range(0, 3) != 0), W'($urandom));
            end
        end
        repeat (2 * NB + 2) tick(1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
